pwm_regs_mc: RTL and testbench
==============================

Name: pwm_regs_mc

Overview:
- Parametrised multi-channel register bank for the PWM signal generator; sits between the SPI/bus decoder and the counter plus NUM_CH PWM channel generators.
- Generalises the single-channel bank:
  - configurable counter width and channel count;
  - double-buffered (shadow/active) period, prescale and compare registers, committed atomically at the period boundary or on software request;
  - atomic multi-byte COUNTER_VAL read via snapshot.

Parameters:
- NUM_CH, 4, number of PWM channels; 1..14.
- CNT_W, 16, counter/period/compare width; one of 8, 16, 24, 32. NB = CNT_W/8 bytes.
- ADDR_W, 8, decoder address width; must satisfy 0x10*(NUM_CH+1) <= 2^ADDR_W.

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  asynchronous active-low reset
- read  in  1  read strobe from decoder
- write  in  1  write strobe from decoder
- addr  in  ADDR_W  register byte address
- data_write  in  8  write data
- data_read  out  8  read data, combinational
- counter_val  in  CNT_W  live counter value
- period_evt  in  1  one-cycle pulse from counter at period wrap
- period  out  CNT_W  active period
- en  out  1  counter enable
- count_reset  out  1  counter reset pulse
- upnotdown  out  1  count direction
- prescale  out  8  active prescale
- pwm_en  out  NUM_CH  per-channel enable
- functions  out  2*NUM_CH  per-channel mode; channel c at [2c+1:2c]
- compare1  out  NUM_CH*CNT_W  active compare1; channel c at [c*CNT_W +: CNT_W]
- compare2  out  NUM_CH*CNT_W  active compare2, same packing
- update_pending  out  1  shadow holds uncommitted data

Behaviour:
- Reset, asynchronous on rst_n, active-low; clock clk. Reset clears all shadow regs, active regs, snapshot, pending flag, reset-pulse counter, and every output to 0.
- Global map:
  - 0x00 CTRL: bit0 en, bit1 upnotdown; immediate, not shadowed.
  - 0x01 PRESCALE: shadowed.
  - 0x02 COUNTER_RESET: write-only, reads 0.
  - 0x03 UPDATE: write-only; any write forces a commit.
  - 0x04 STATUS: read-only; bit0 update_pending.
  - 0x08+i PERIOD byte i: shadowed.
  - 0x0C+i COUNTER_VAL byte i: read-only.
- Channel c map (base B = 0x10*(c+1)):
  - B+0 CH_CTRL: bit0 pwm_en, bits2:1 functions; immediate.
  - B+4+i COMPARE1 byte i: shadowed.
  - B+8+i COMPARE2 byte i: shadowed.
- Byte index i < NB. Bytes i >= NB, and all unmapped addresses, read 0; writes to them are ignored.
- Writes take effect at the next clk edge. Read data is combinational from current register state, so a same-cycle read and write to the same address returns the pre-write value.
- Readback of shadowed registers returns the shadow value.
- Shadow commit (active <= shadow for period, prescale and all compares, in one cycle):
  - Triggers: (period_evt && update_pending), or any write to UPDATE.
  - Both triggers in the same cycle produce a single commit.
  - Active outputs change the cycle after the trigger.
- update_pending:
  - Set by any write to a shadowed byte.
  - Cleared on commit.
  - Shadow write in the same cycle as a commit: the commit uses pre-write shadow contents, and pending stays 1.
- count_reset:
  - A write to 0x02 drives count_reset high for exactly 2 cycles, starting the cycle after the write.
  - A rewrite during the pulse restarts it, giving 2 cycles from the rewrite.
  - count_reset does not commit shadows.
- COUNTER_VAL snapshot:
  - A read of 0x0C returns live counter_val[7:0] and captures counter_val[CNT_W-1:8] into the snapshot register at that clk edge.
  - Reads of 0x0D..0x0C+NB-1 return snapshot bytes.
  - Snapshot holds until the next 0x0C read.
  - With CNT_W=8 there is no snapshot register.
- read and write are independent; both may be high in the same cycle.

Decomposition:
- Shared package pwm_regs_pkg holds:
  - address offsets (CTRL, PRESCALE, CNT_RST, UPDATE, STATUS, PERIOD_BASE, CNTVAL_BASE, CH_STRIDE, CH_CTRL_OFS, CMP1_OFS, CMP2_OFS);
  - CTRL/CH_CTRL bit positions;
  - count_reset pulse length (2).
- One natural sub-module, pwm_shadow_reg: parametrised CNT_W byte-writable shadow plus active register with commit and byte readback. Instantiate it for period and for each channel's compare1/compare2.

Test Plan:
- Reset, then read every address: all 0; all outputs 0; update_pending=0.
- Shadow commit on period boundary: write PERIOD 0x08=0x34, 0x09=0x12 → readback 0x1234, period output still 0, STATUS=1. Pulse period_evt → period=0x1234 next cycle, STATUS=0.
- Forced commit via UPDATE: write ch2 COMPARE1 = 0x00A0, then UPDATE → compare1[2] active=0x00A0 next cycle. Then write COMPARE2 in the same cycle as period_evt with pending=1 → compare2 unchanged, pending stays 1.
- count_reset pulse and restart: write 0x02 → count_reset high for exactly cycles +1 and +2. Rewrite 0x02 at +1 → pulse lasts through +3.
- Snapshot atomicity: counter_val=0x12FF, read 0x0C → returns 0xFF. Counter moves to 0x1300, read 0x0D → returns 0x12.
- Immediate control, parameter sweep and bounds: with NUM_CH=1, CNT_W=8, channel CH_CTRL write 0x05 → pwm_en=1, functions=2'b10 next cycle. Write 0x09 (byte ≥ NB) → ignored, reads 0.

Source files
------------

// File: rtl/pwm_regs_pkg.sv
// ---------------------------------------------------------------------------
// pwm_regs_pkg
// Shared definitions for the multi-channel PWM register bank.
//
// Contents:
//   - Byte offsets inside each 16-byte register block. Block 0 holds the
//     global registers. Block c+1 holds the registers for channel c.
//   - Bit positions inside the CTRL, STATUS and CH_CTRL registers.
//   - Length of the counter-reset pulse.
//   - Helper that checks whether an offset falls inside a multi-byte
//     register lane.
// ---------------------------------------------------------------------------
package pwm_regs_pkg;

  // Block geometry: the address splits into a block number and a 4-bit offset.
  localparam int         CH_STRIDE    = 16;
  localparam int         BLK_SHIFT    = 4;

  // Global block offsets
  localparam logic [3:0] CTRL_OFS     = 4'h0;
  localparam logic [3:0] PRESCALE_OFS = 4'h1;
  localparam logic [3:0] CNT_RST_OFS  = 4'h2;
  localparam logic [3:0] UPDATE_OFS   = 4'h3;
  localparam logic [3:0] STATUS_OFS   = 4'h4;
  localparam logic [3:0] PERIOD_BASE  = 4'h8;
  localparam logic [3:0] CNTVAL_BASE  = 4'hC;

  // Channel block offsets
  localparam logic [3:0] CH_CTRL_OFS  = 4'h0;
  localparam logic [3:0] CMP1_OFS     = 4'h4;
  localparam logic [3:0] CMP2_OFS     = 4'h8;

  // Register bit positions
  localparam int         CTRL_EN_BIT     = 0;
  localparam int         CTRL_DIR_BIT    = 1;
  localparam int         STATUS_PEND_BIT = 0;
  localparam int         CH_EN_BIT       = 0;
  localparam int         CH_FN_LSB       = 1;

  // count_reset stays high for this many cycles after a write.
  localparam logic [1:0] CNT_RST_LEN  = 2'd2;

  // Returns true when offset ofs selects byte i of a 4-byte lane starting
  // at base, and i is less than nb.
  // Lanes are 4-byte aligned, so only the low two bits vary inside a lane.
  function automatic logic in_lane(input logic [3:0] ofs,
                                   input logic [3:0] base,
                                   input int         nb);
    return (ofs[3:2] == base[3:2]) && (int'(ofs[1:0]) < nb);
  endfunction

endpackage

// File: rtl/pwm_regs_mc_if.sv
// ---------------------------------------------------------------------------
// pwm_regs_mc_if
// Byte-wide register bus between the SPI/bus decoder and the PWM register
// bank.
//
// Signals:
//   read       - read strobe
//   write      - write strobe
//   addr       - byte address
//   data_write - write data
//   data_read  - read data. The bank drives it combinationally.
//
// Modports:
//   master - the decoder side
//   slave  - the register bank side
// ---------------------------------------------------------------------------
interface pwm_regs_mc_if #(
  parameter int ADDR_W = 8
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_write;
  logic [7:0]        data_read;

  modport master (output read, output write, output addr, output data_write,
                  input  data_read);
  modport slave  (input  read, input  write, input  addr, input  data_write,
                  output data_read);
endinterface

// File: rtl/pwm_shadow_reg.sv
// ---------------------------------------------------------------------------
// pwm_shadow_reg
// Double-buffered register of W bits, written one byte at a time.
//
// Behaviour:
//   - Byte writes go to the shadow copy only.
//   - A commit copies the shadow into the active copy in one cycle.
//   - If a commit and a write land in the same cycle, the commit takes the
//     shadow contents from before the write.
//   - Readback returns the selected shadow byte. It returns 0 when the byte
//     index is W/8 or higher.
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   wr_en      - byte write strobe
//   wr_idx     - index of the byte to write
//   wr_data    - write data byte
//   commit     - copy shadow to active at this edge
//   rd_idx     - index of the byte to read back
//   rd_data    - shadow readback byte, combinational
//   active     - active value
// ---------------------------------------------------------------------------
module pwm_shadow_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [1:0]   wr_idx,
  input  logic [7:0]   wr_data,
  input  logic         commit,
  input  logic [1:0]   rd_idx,
  output logic [7:0]   rd_data,
  output logic [W-1:0] active
);
  localparam int NB = W / 8;

  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] active_q, active_d;
  logic [7:0]   rd_data_s;

  // Next-state logic: byte merge into the shadow, and the shadow-to-active commit.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NB; i++) begin
      shadow_d[i*8 +: 8] = (wr_en && (int'(wr_idx) == i)) ? wr_data
                                                          : shadow_q[i*8 +: 8];
    end
    active_d = commit ? shadow_q : active_q;
  end

  // Shadow and active state flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= {W{1'b0}};
      active_q <= {W{1'b0}};
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Shadow byte readback mux.
  always_comb begin
    rd_data_s = 8'h00;
    for (int i = 0; i < NB; i++) begin
      rd_data_s = (int'(rd_idx) == i) ? shadow_q[i*8 +: 8] : rd_data_s;
    end
  end

  assign rd_data = rd_data_s;
  assign active  = active_q;

endmodule

// File: rtl/pwm_regs_mc.sv
// ---------------------------------------------------------------------------
// pwm_regs_mc
// Register bank for a PWM generator with NUM_CH channels. It sits between the
// bus decoder and the counter plus the channel generators.
//
// Parameters:
//   NUM_CH - number of channels (1..14)
//   CNT_W  - counter width: 8, 16, 24 or 32
//   ADDR_W - address width. Must cover 16*(NUM_CH+1) bytes.
//
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   bus            - register bus, slave side
//   counter_val    - live counter value
//   period_evt     - one-cycle pulse at each period wrap
//   period         - active period
//   prescale       - active prescale
//   en, upnotdown  - counter enable and count direction
//   count_reset    - counter reset pulse, 2 cycles long
//   pwm_en         - per-channel enable
//   functions      - per-channel mode. Channel c is at [2c+1:2c].
//   compare1/2     - active compare values. Channel c is at [c*CNT_W +: CNT_W].
//   update_pending - the shadow copies hold data not yet committed
//
// Period, prescale and compare values are double-buffered. They commit
// together at a period wrap when an update is pending, or immediately on a
// write to UPDATE.
// ---------------------------------------------------------------------------
module pwm_regs_mc
  import pwm_regs_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pwm_regs_mc_if.slave            bus,
  input  logic [CNT_W-1:0]        counter_val,
  input  logic                    period_evt,
  output logic [CNT_W-1:0]        period,
  output logic                    en,
  output logic                    count_reset,
  output logic                    upnotdown,
  output logic [7:0]              prescale,
  output logic [NUM_CH-1:0]       pwm_en,
  output logic [2*NUM_CH-1:0]     functions,
  output logic [NUM_CH*CNT_W-1:0] compare1,
  output logic [NUM_CH*CNT_W-1:0] compare2,
  output logic                    update_pending
);
  localparam int NB    = CNT_W / 8;
  localparam int BLK_W = ADDR_W - BLK_SHIFT;

  // ---------------- address decode ----------------
  logic [BLK_W-1:0]  blk_s;
  logic [3:0]        ofs_s;
  logic              is_global_s;
  logic [NUM_CH-1:0] ch_hit_s;

  assign blk_s       = bus.addr[ADDR_W-1:BLK_SHIFT];
  assign ofs_s       = bus.addr[BLK_SHIFT-1:0];
  assign is_global_s = (blk_s == {BLK_W{1'b0}});

  logic              wr_ctrl_s, wr_psc_s, wr_crst_s, wr_upd_s, wr_per_s;
  logic              rd_cntval0_s;
  logic [NUM_CH-1:0] wr_chctrl_s, wr_cmp1_s, wr_cmp2_s;
  logic              shadow_wr_s, commit_s;

  assign wr_ctrl_s    = bus.write && is_global_s && (ofs_s == CTRL_OFS);
  assign wr_psc_s     = bus.write && is_global_s && (ofs_s == PRESCALE_OFS);
  assign wr_crst_s    = bus.write && is_global_s && (ofs_s == CNT_RST_OFS);
  assign wr_upd_s     = bus.write && is_global_s && (ofs_s == UPDATE_OFS);
  assign wr_per_s     = bus.write && is_global_s && in_lane(ofs_s, PERIOD_BASE, NB);
  assign rd_cntval0_s = bus.read  && is_global_s && (ofs_s == CNTVAL_BASE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_dec
    assign ch_hit_s[c]    = (blk_s == BLK_W'(c + 1));
    assign wr_chctrl_s[c] = bus.write && ch_hit_s[c] && (ofs_s == CH_CTRL_OFS);
    assign wr_cmp1_s[c]   = bus.write && ch_hit_s[c] && in_lane(ofs_s, CMP1_OFS, NB);
    assign wr_cmp2_s[c]   = bus.write && ch_hit_s[c] && in_lane(ofs_s, CMP2_OFS, NB);
  end

  assign shadow_wr_s = wr_psc_s || wr_per_s || (|wr_cmp1_s) || (|wr_cmp2_s);
  // If UPDATE and a pending period wrap land in the same cycle, the OR
  // still gives one commit.
  assign commit_s    = wr_upd_s || (period_evt && update_pending);

  // ---------------- immediate and control state ----------------
  logic              en_q, en_d;
  logic              dir_q, dir_d;
  logic              pending_q, pending_d;
  logic [1:0]        crst_cnt_q, crst_cnt_d;
  logic [NUM_CH-1:0] ch_en_q, ch_en_d;
  logic [2*NUM_CH-1:0] ch_fn_q, ch_fn_d;

  // Next state for CTRL, CH_CTRL, the pending flag and the reset-pulse counter.
  always_comb begin
    en_d  = wr_ctrl_s ? bus.data_write[CTRL_EN_BIT]  : en_q;
    dir_d = wr_ctrl_s ? bus.data_write[CTRL_DIR_BIT] : dir_q;
    ch_en_d = ch_en_q;
    ch_fn_d = ch_fn_q;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_en_d[c]       = wr_chctrl_s[c] ? bus.data_write[CH_EN_BIT] : ch_en_q[c];
      ch_fn_d[2*c +: 2] = wr_chctrl_s[c] ? bus.data_write[CH_FN_LSB +: 2]
                                         : ch_fn_q[2*c +: 2];
    end
    // A shadow write in the commit cycle is not in that commit, so it wins.
    if (shadow_wr_s) begin
      pending_d = 1'b1;
    end else if (commit_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    // A rewrite while the pulse is running reloads the counter.
    if (wr_crst_s) begin
      crst_cnt_d = CNT_RST_LEN;
    end else if (crst_cnt_q != 2'd0) begin
      crst_cnt_d = crst_cnt_q - 2'd1;
    end else begin
      crst_cnt_d = crst_cnt_q;
    end
  end

  // Control and status flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      dir_q      <= 1'b0;
      pending_q  <= 1'b0;
      crst_cnt_q <= 2'd0;
      ch_en_q    <= {NUM_CH{1'b0}};
      ch_fn_q    <= {(2*NUM_CH){1'b0}};
    end else begin
      en_q       <= en_d;
      dir_q      <= dir_d;
      pending_q  <= pending_d;
      crst_cnt_q <= crst_cnt_d;
      ch_en_q    <= ch_en_d;
      ch_fn_q    <= ch_fn_d;
    end
  end

  // ---------------- COUNTER_VAL snapshot ----------------
  logic [7:0] snap_rd_s;

  if (CNT_W > 8) begin : g_snap
    logic [CNT_W-9:0] snap_q, snap_d;

    // Reading byte 0 latches the upper bytes, so the following byte reads
    // all come from the same counter value.
    always_comb begin
      snap_d = rd_cntval0_s ? counter_val[CNT_W-1:8] : snap_q;
    end

    // Snapshot flop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        snap_q <= {(CNT_W-8){1'b0}};
      end else begin
        snap_q <= snap_d;
      end
    end

    // Snapshot byte select. Byte 1 of COUNTER_VAL is snapshot byte 0.
    always_comb begin
      snap_rd_s = 8'h00;
      for (int i = 1; i < NB; i++) begin
        snap_rd_s = (int'(ofs_s[1:0]) == i) ? snap_q[(i-1)*8 +: 8] : snap_rd_s;
      end
    end
  end else begin : g_nosnap
    assign snap_rd_s = 8'h00;
  end

  // ---------------- shadowed registers ----------------
  logic [7:0] psc_rd_s, per_rd_s;
  logic [7:0] cmp1_rd_s [NUM_CH];
  logic [7:0] cmp2_rd_s [NUM_CH];

  pwm_shadow_reg #(.W(8)) u_prescale (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_psc_s),
    .wr_idx  (2'd0),
    .wr_data (bus.data_write),
    .commit  (commit_s),
    .rd_idx  (2'd0),
    .rd_data (psc_rd_s),
    .active  (prescale)
  );

  pwm_shadow_reg #(.W(CNT_W)) u_period (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_per_s),
    .wr_idx  (ofs_s[1:0]),
    .wr_data (bus.data_write),
    .commit  (commit_s),
    .rd_idx  (ofs_s[1:0]),
    .rd_data (per_rd_s),
    .active  (period)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_shadow_reg #(.W(CNT_W)) u_cmp1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_cmp1_s[c]),
      .wr_idx  (ofs_s[1:0]),
      .wr_data (bus.data_write),
      .commit  (commit_s),
      .rd_idx  (ofs_s[1:0]),
      .rd_data (cmp1_rd_s[c]),
      .active  (compare1[c*CNT_W +: CNT_W])
    );
    pwm_shadow_reg #(.W(CNT_W)) u_cmp2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_cmp2_s[c]),
      .wr_idx  (ofs_s[1:0]),
      .wr_data (bus.data_write),
      .commit  (commit_s),
      .rd_idx  (ofs_s[1:0]),
      .rd_data (cmp2_rd_s[c]),
      .active  (compare2[c*CNT_W +: CNT_W])
    );
  end

  // ---------------- read mux ----------------
  logic [7:0] rd_s;

  // Read data comes combinationally from the current state. A write in the
  // same cycle therefore does not show up until the next cycle.
  always_comb begin
    rd_s = 8'h00;
    if (is_global_s) begin
      case (ofs_s)
        CTRL_OFS:     rd_s = {6'b000000, dir_q, en_q};
        PRESCALE_OFS: rd_s = psc_rd_s;
        STATUS_OFS:   rd_s = {7'b0000000, pending_q};
        CNTVAL_BASE:  rd_s = counter_val[7:0];
        default: begin
          if (in_lane(ofs_s, PERIOD_BASE, NB)) begin
            rd_s = per_rd_s;
          end else if (in_lane(ofs_s, CNTVAL_BASE, NB)) begin
            rd_s = snap_rd_s;
          end else begin
            rd_s = 8'h00;
          end
        end
      endcase
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_hit_s[c]) begin
          case (ofs_s)
            CH_CTRL_OFS: rd_s = {5'b00000, ch_fn_q[2*c +: 2], ch_en_q[c]};
            default: begin
              if (in_lane(ofs_s, CMP1_OFS, NB)) begin
                rd_s = cmp1_rd_s[c];
              end else if (in_lane(ofs_s, CMP2_OFS, NB)) begin
                rd_s = cmp2_rd_s[c];
              end else begin
                rd_s = 8'h00;
              end
            end
          endcase
        end else begin
          rd_s = rd_s;
        end
      end
    end
  end

  assign bus.data_read  = rd_s;
  assign en             = en_q;
  assign upnotdown      = dir_q;
  assign count_reset    = (crst_cnt_q != 2'd0);
  assign pwm_en         = ch_en_q;
  assign functions      = ch_fn_q;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_pwm_regs_mc.sv
// ---------------------------------------------------------------------------
// tb_pwm_regs_mc
// Directed testbench for pwm_regs_mc. It builds two instances:
//   - u_dut  : default parameters (NUM_CH=4, CNT_W=16)
//   - u_dut8 : NUM_CH=1, CNT_W=8
// Inputs change on the falling clock edge. Outputs are sampled just after
// the falling edge.
// ---------------------------------------------------------------------------
module tb_pwm_regs_mc;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Default instance
  pwm_regs_mc_if #(.ADDR_W(8)) b ();
  logic [15:0] counter_val;
  logic        period_evt;
  logic [15:0] period;
  logic        en, count_reset, upnotdown, update_pending;
  logic [7:0]  prescale;
  logic [3:0]  pwm_en;
  logic [7:0]  functions;
  logic [63:0] compare1, compare2;

  pwm_regs_mc #(.NUM_CH(4), .CNT_W(16), .ADDR_W(8)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (b),
    .counter_val    (counter_val),
    .period_evt     (period_evt),
    .period         (period),
    .en             (en),
    .count_reset    (count_reset),
    .upnotdown      (upnotdown),
    .prescale       (prescale),
    .pwm_en         (pwm_en),
    .functions      (functions),
    .compare1       (compare1),
    .compare2       (compare2),
    .update_pending (update_pending)
  );

  // Narrow instance
  pwm_regs_mc_if #(.ADDR_W(8)) b8 ();
  logic [7:0] counter_val8;
  logic       period_evt8;
  logic [7:0] period8;
  logic       en8, count_reset8, upnotdown8, update_pending8;
  logic [7:0] prescale8;
  logic [0:0] pwm_en8;
  logic [1:0] functions8;
  logic [7:0] compare1_8, compare2_8;

  pwm_regs_mc #(.NUM_CH(1), .CNT_W(8), .ADDR_W(8)) u_dut8 (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (b8),
    .counter_val    (counter_val8),
    .period_evt     (period_evt8),
    .period         (period8),
    .en             (en8),
    .count_reset    (count_reset8),
    .upnotdown      (upnotdown8),
    .prescale       (prescale8),
    .pwm_en         (pwm_en8),
    .functions      (functions8),
    .compare1       (compare1_8),
    .compare2       (compare2_8),
    .update_pending (update_pending8)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One write cycle. It starts and ends on a falling edge.
  task automatic wr(input bit s8, input logic [7:0] a, input logic [7:0] d);
    if (s8) begin
      b8.write = 1'b1; b8.addr = a; b8.data_write = d;
    end else begin
      b.write = 1'b1; b.addr = a; b.data_write = d;
    end
    @(negedge clk);
    if (s8) b8.write = 1'b0;
    else    b.write  = 1'b0;
  endtask

  // One read cycle. Data is sampled before the rising edge.
  task automatic rd(input bit s8, input logic [7:0] a, output logic [7:0] d);
    if (s8) begin
      b8.read = 1'b1; b8.addr = a;
    end else begin
      b.read = 1'b1; b.addr = a;
    end
    #1;
    d = s8 ? b8.data_read : b.data_read;
    @(negedge clk);
    if (s8) b8.read = 1'b0;
    else    b.read  = 1'b0;
  endtask

  logic [7:0] rdata;

  initial begin
    rst_n = 1'b0;
    b.read = 1'b0;  b.write = 1'b0;  b.addr = 8'h00;  b.data_write = 8'h00;
    b8.read = 1'b0; b8.write = 1'b0; b8.addr = 8'h00; b8.data_write = 8'h00;
    counter_val = 16'h0000; period_evt = 1'b0;
    counter_val8 = 8'h00;   period_evt8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- reset state ----
    chk("rst_period", 64'(period), 64'h0);
    chk("rst_en", 64'(en), 64'h0);
    chk("rst_count_reset", 64'(count_reset), 64'h0);
    chk("rst_upnotdown", 64'(upnotdown), 64'h0);
    chk("rst_prescale", 64'(prescale), 64'h0);
    chk("rst_pwm_en", 64'(pwm_en), 64'h0);
    chk("rst_functions", 64'(functions), 64'h0);
    chk("rst_compare1", compare1, 64'h0);
    chk("rst_compare2", compare2, 64'h0);
    chk("rst_pending", 64'(update_pending), 64'h0);
    chk("rst8_period", 64'(period8), 64'h0);
    chk("rst8_pwm_en", 64'(pwm_en8), 64'h0);
    for (int a = 0; a < 96; a++) begin
      rd(1'b0, 8'(a), rdata);
      chk($sformatf("rst_rd_%02h", a), 64'(rdata), 64'h0);
    end
    for (int a = 0; a < 32; a++) begin
      rd(1'b1, 8'(a), rdata);
      chk($sformatf("rst8_rd_%02h", a), 64'(rdata), 64'h0);
    end

    // ---- PERIOD commit at period boundary ----
    wr(1'b0, 8'h08, 8'h34);
    wr(1'b0, 8'h09, 8'h12);
    rd(1'b0, 8'h08, rdata); chk("per_rd0", 64'(rdata), 64'h34);
    rd(1'b0, 8'h09, rdata); chk("per_rd1", 64'(rdata), 64'h12);
    chk("per_not_active", 64'(period), 64'h0);
    rd(1'b0, 8'h04, rdata); chk("status_pend", 64'(rdata), 64'h01);
    period_evt = 1'b1;
    @(negedge clk);
    period_evt = 1'b0;
    chk("per_committed", 64'(period), 64'h1234);
    rd(1'b0, 8'h04, rdata); chk("status_clr", 64'(rdata), 64'h00);

    // ---- forced commit through UPDATE ----
    wr(1'b0, 8'h34, 8'hA0);
    wr(1'b0, 8'h35, 8'h00);
    chk("cmp1_pend", 64'(update_pending), 64'h1);
    chk("cmp1_not_active", compare1, 64'h0);
    wr(1'b0, 8'h03, 8'h00);
    chk("cmp1_committed", compare1, 64'h0000_00A0_0000_0000);
    chk("cmp1_pend_clr", 64'(update_pending), 64'h0);

    // Shadow write in the same cycle as a commit: the commit uses old data
    wr(1'b0, 8'h01, 8'h07);
    chk("psc_pend", 64'(update_pending), 64'h1);
    period_evt = 1'b1;
    wr(1'b0, 8'h38, 8'h55);
    period_evt = 1'b0;
    chk("psc_committed", 64'(prescale), 64'h07);
    chk("cmp2_unchanged", compare2, 64'h0);
    chk("cmp2_pend_kept", 64'(update_pending), 64'h1);
    rd(1'b0, 8'h38, rdata); chk("cmp2_shadow_rd", 64'(rdata), 64'h55);
    wr(1'b0, 8'h03, 8'h00);
    chk("cmp2_committed", compare2, 64'h0000_0055_0000_0000);
    chk("cmp2_pend_clr", 64'(update_pending), 64'h0);

    // ---- count_reset pulse (and no commit side effect) ----
    wr(1'b0, 8'h08, 8'h99);
    wr(1'b0, 8'h02, 8'h01);
    chk("crst_p1", 64'(count_reset), 64'h1);
    @(negedge clk);
    chk("crst_p2", 64'(count_reset), 64'h1);
    @(negedge clk);
    chk("crst_p3_low", 64'(count_reset), 64'h0);
    chk("crst_no_commit", 64'(period), 64'h1234);
    chk("crst_pend_kept", 64'(update_pending), 64'h1);
    // Restart: rewrite during cycle +1
    b.write = 1'b1; b.addr = 8'h02; b.data_write = 8'h01;
    @(negedge clk);
    chk("crst_r1", 64'(count_reset), 64'h1);
    @(negedge clk);
    b.write = 1'b0;
    chk("crst_r2", 64'(count_reset), 64'h1);
    @(negedge clk);
    chk("crst_r3", 64'(count_reset), 64'h1);
    @(negedge clk);
    chk("crst_r4_low", 64'(count_reset), 64'h0);
    rd(1'b0, 8'h02, rdata); chk("crst_rd0", 64'(rdata), 64'h00);

    // UPDATE and a period wrap in the same cycle commit once
    period_evt = 1'b1;
    wr(1'b0, 8'h03, 8'h00);
    period_evt = 1'b0;
    chk("dual_commit_per", 64'(period), 64'h1299);
    chk("dual_commit_pend", 64'(update_pending), 64'h0);

    // ---- COUNTER_VAL snapshot ----
    counter_val = 16'h12FF;
    rd(1'b0, 8'h0C, rdata); chk("snap_lo", 64'(rdata), 64'hFF);
    counter_val = 16'h1300;
    rd(1'b0, 8'h0D, rdata); chk("snap_hi_held", 64'(rdata), 64'h12);
    rd(1'b0, 8'h0E, rdata); chk("snap_oob", 64'(rdata), 64'h00);
    rd(1'b0, 8'h0C, rdata); chk("snap_lo2", 64'(rdata), 64'h00);
    rd(1'b0, 8'h0D, rdata); chk("snap_hi2", 64'(rdata), 64'h13);

    // ---- immediate control and unmapped addresses ----
    wr(1'b0, 8'h00, 8'h03);
    chk("ctrl_en", 64'(en), 64'h1);
    chk("ctrl_dir", 64'(upnotdown), 64'h1);
    rd(1'b0, 8'h00, rdata); chk("ctrl_rd", 64'(rdata), 64'h03);
    wr(1'b0, 8'h40, 8'h05);
    chk("ch3_pwm_en", 64'(pwm_en), 64'h8);
    chk("ch3_functions", 64'(functions), 64'hC0 & 64'h80);
    rd(1'b0, 8'h40, rdata); chk("ch3_rd", 64'(rdata), 64'h05);
    wr(1'b0, 8'h50, 8'h07);
    chk("unmapped_ch_pwm_en", 64'(pwm_en), 64'h8);
    rd(1'b0, 8'h50, rdata); chk("unmapped_ch_rd", 64'(rdata), 64'h00);
    wr(1'b0, 8'h36, 8'h77);
    rd(1'b0, 8'h36, rdata); chk("cmp_oob_rd", 64'(rdata), 64'h00);
    chk("cmp_oob_no_pend", 64'(update_pending), 64'h0);

    // ---- NUM_CH=1, CNT_W=8 instance ----
    wr(1'b1, 8'h10, 8'h05);
    chk("n8_pwm_en", 64'(pwm_en8), 64'h1);
    chk("n8_functions", 64'(functions8), 64'h2);
    rd(1'b1, 8'h10, rdata); chk("n8_chctrl_rd", 64'(rdata), 64'h05);
    wr(1'b1, 8'h09, 8'hAB);
    rd(1'b1, 8'h09, rdata); chk("n8_per_oob_rd", 64'(rdata), 64'h00);
    chk("n8_per_oob_no_pend", 64'(update_pending8), 64'h0);
    wr(1'b1, 8'h08, 8'h42);
    rd(1'b1, 8'h08, rdata); chk("n8_per_rd", 64'(rdata), 64'h42);
    chk("n8_pend", 64'(update_pending8), 64'h1);
    chk("n8_per_not_active", 64'(period8), 64'h0);
    counter_val8 = 8'h7E;
    rd(1'b1, 8'h0C, rdata); chk("n8_cntval", 64'(rdata), 64'h7E);
    rd(1'b1, 8'h0D, rdata); chk("n8_cntval_oob", 64'(rdata), 64'h00);
    wr(1'b1, 8'h03, 8'h00);
    chk("n8_per_committed", 64'(period8), 64'h42);
    chk("n8_pend_clr", 64'(update_pending8), 64'h0);
    chk("n8_main_untouched", 64'(period), 64'h1299);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
